dac_serial_rx: RTL and testbench
================================

Name: dac_serial_rx

Overview:
- Receiver end of the two-channel serial DAC link.
- Samples serial data lines DL/DR and latch lines LL/LR in the clk_12 domain, and rebuilds each 16-bit signed word.
- Pairs left and right words into one stereo sample and flags framing errors.
- Used as the loopback checker behind the DAC and as the front end for serial converters that use the same framing.

Parameters:
- WIDTH, 16, word length in bits, MSB first.
- SYNC_STAGES, 2, synchronizer flops on DL/DR/LL/LR; 0 means inputs are already synchronous.
- CNT_W, 8, bit-counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk_12  in  1  bit clock; every rising edge samples one serial bit.
- reset  in  1  asynchronous, active-high reset.
- DL  in  1  left serial data.
- DR  in  1  right serial data.
- LL  in  1  left latch.
- LR  in  1  right latch.
- leftOut  out  WIDTH  last captured left word (signed).
- rightOut  out  WIDTH  last captured right word (signed).
- leftValid  out  1  one-cycle pulse when leftOut updates.
- rightValid  out  1  one-cycle pulse when rightOut updates.
- leftErr  out  1  asserted together with leftValid when the frame bit count was not WIDTH.
- rightErr  out  1  asserted together with rightValid when the frame bit count was not WIDTH.
- pairValid  out  1  one-cycle pulse: leftOut/rightOut hold a fresh matched pair.
- overrun  out  1  sticky flag: a channel captured twice before the other captured once; cleared only by reset.

Behaviour:
- Reset: all outputs 0, shift registers 0, counters 0, synchronizers 0, both channels disarmed.
- Each channel uses its synchronized inputs (d, l). On every edge:
  - shreg <= {shreg[WIDTH-2:0], d}
  - l_q <= l
  - cnt <= sat(cnt+1)
- Falling-latch event: l_q==1 and l==0.
  - The word is the WIDTH bits in shreg before this edge's shift: the bits sampled up to and including the last cycle in which the latch was high.
  - The bit sampled in the event cycle belongs to the next frame.
- On an event:
  - cnt <= 1.
  - If the channel is disarmed: set armed and produce no output. The first event after reset only aligns the frame.
  - If the channel is armed: out <= shreg (pre-shift), valid pulses for 1 cycle, err = (cnt != WIDTH).
  - out and valid update on the edge after the event edge.
- Latency: the LSB of a word appears on out SYNC_STAGES+1 cycles after it is sampled at the pins.
- A latch held low or held high generates no events. cnt saturates and the next frame reports err=1.
- A frame with err=1 still updates out; the data is passed through.
- Pairing state machine, states IDLE, GOT_L, GOT_R:
  - IDLE: leftValid -> GOT_L; rightValid -> GOT_R; both in the same cycle -> pairValid pulses the next cycle, stay IDLE.
  - GOT_L: rightValid -> pairValid next cycle, go to IDLE. leftValid again -> overrun=1, stay GOT_L (newer left kept). Both -> pairValid, go to GOT_L.
  - GOT_R: symmetric to GOT_L.
- pairValid never pulses in the same cycle as the valid that completes the pair; it always follows one cycle later.
- Reset mid-frame: captured data and pairing state are discarded; both channels re-arm on their next falling latch.

Decomposition:
- Package dac_rx_pkg holds:
  - WIDTH_DEF = 16, CNT_W_DEF = 8.
  - typedef sample_t = logic signed [15:0].
  - enum pair_state_t {IDLE, GOT_L, GOT_R}.
- One sub-module, dac_rx_channel: synchronizer, shift register, latch-edge detect, arm flag, bit counter, out/valid/err. It is instantiated twice.
- The top level holds the pairing state machine and the overrun flag.

Test Plan:
- Reset, then arming frame, then 16-bit frames 0x0009 left / 0x0006 right with simultaneous latches.
  -> leftOut=0x0009, rightOut=0x0006, both valid same cycle, err=0, pairValid 1 cycle later.
  -> No output from the arming frame.
- Left latch 8 cycles ahead of right, words 0x8000 / 0x7FFF.
  -> leftValid, then rightValid 8 cycles later, then pairValid; leftOut reads -32768.
- Short frame: 12 clocks between left latch falls.
  -> leftValid with leftErr=1; the next 16-bit frame gives leftErr=0.
- Two left frames (0x0004, 0x0005) before any right frame.
  -> overrun=1 and stays 1; after right frame 0x0008, pairValid with leftOut=0x0005.
- Latch held high for 300 cycles, then falls.
  -> exactly one leftValid with leftErr=1 (counter saturated at 255).
- reset asserted mid-frame for 1 cycle.
  -> outputs cleared immediately; the first post-reset latch fall gives no valid; the second gives a correct word.

Source files
------------

// File: rtl/dac_rx_pkg.sv
// Shared types and defaults for the serial DAC link receiver.
package dac_rx_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 8;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_L = 2'd1,
        GOT_R = 2'd2
    } pair_state_t;

endpackage

// File: rtl/dac_rx_channel.sv
// One serial channel: input synchronizer, MSB-first shift register, latch fall
// detection, frame bit counter and the registered word/valid/err outputs.
module dac_rx_channel #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             d_i,
    input  logic             l_i,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic d_s;
    logic l_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign d_s = d_i;
            assign l_s = l_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] d_sync_q;
            logic [SYNC_STAGES-1:0] l_sync_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    d_sync_q <= '0;
                    l_sync_q <= '0;
                end else begin
                    d_sync_q[0] <= d_i;
                    l_sync_q[0] <= l_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        d_sync_q[i] <= d_sync_q[i-1];
                        l_sync_q[i] <= l_sync_q[i-1];
                    end
                end
            end

            assign d_s = d_sync_q[SYNC_STAGES-1];
            assign l_s = l_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             l_q;
    logic             armed_q, armed_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             fall;

    // The word is taken from the pre-shift register: the bit sampled in the
    // fall cycle already belongs to the next frame.
    always_comb begin
        shreg_d = {shreg_q[WIDTH-2:0], d_s};
        fall    = l_q & ~l_s;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        armed_d = armed_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (fall) begin
            cnt_d   = CNT_ONE;
            armed_d = 1'b1;
            if (armed_q) begin
                out_d   = shreg_q;
                valid_d = 1'b1;
                err_d   = (cnt_q != CNT_FULL);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            l_q     <= 1'b0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            l_q     <= l_s;
            armed_q <= armed_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/dac_serial_rx.sv
// Two-channel serial DAC receiver: per-channel word capture plus left/right
// pairing with a sticky overrun flag.
module dac_serial_rx
    import dac_rx_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk_12,
    input  logic             reset,
    input  logic             DL,
    input  logic             DR,
    input  logic             LL,
    input  logic             LR,
    output logic [WIDTH-1:0] leftOut,
    output logic [WIDTH-1:0] rightOut,
    output logic             leftValid,
    output logic             rightValid,
    output logic             leftErr,
    output logic             rightErr,
    output logic             pairValid,
    output logic             overrun,
    output logic [1:0]       pair_state_o
);

    dac_rx_channel #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) u_left (
        .clk_i   (clk_12),
        .rst_i   (reset),
        .d_i     (DL),
        .l_i     (LL),
        .out_o   (leftOut),
        .valid_o (leftValid),
        .err_o   (leftErr)
    );

    dac_rx_channel #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) u_right (
        .clk_i   (clk_12),
        .rst_i   (reset),
        .d_i     (DR),
        .l_i     (LR),
        .out_o   (rightOut),
        .valid_o (rightValid),
        .err_o   (rightErr)
    );

    pair_state_t state_q, state_d;
    logic        pair_q, pair_d;
    logic        ovr_q, ovr_d;

    // Pairing is registered so pairValid always trails the completing valid
    // by one cycle, with leftOut/rightOut already stable.
    always_comb begin
        state_d = state_q;
        pair_d  = 1'b0;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (leftValid && rightValid) pair_d = 1'b1;
                else if (leftValid)          state_d = GOT_L;
                else if (rightValid)         state_d = GOT_R;
            end
            GOT_L: begin
                if (leftValid && rightValid) begin
                    pair_d = 1'b1;
                end else if (rightValid) begin
                    pair_d  = 1'b1;
                    state_d = IDLE;
                end else if (leftValid) begin
                    ovr_d = 1'b1;
                end
            end
            GOT_R: begin
                if (leftValid && rightValid) begin
                    pair_d = 1'b1;
                end else if (leftValid) begin
                    pair_d  = 1'b1;
                    state_d = IDLE;
                end else if (rightValid) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pair_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pairValid    = pair_q;
    assign overrun      = ovr_q;
    assign pair_state_o = state_q;

endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed bench for dac_serial_rx: streams framed words into both channels
// and scoreboards every valid/pair pulse against hand-computed words.
module tb_dac_serial_rx;
    import dac_rx_pkg::*;

    // clock / reset
    logic        clk_12 = 1'b0;
    logic        reset  = 1'b1;
    logic        DL = 1'b0, DR = 1'b0, LL = 1'b0, LR = 1'b0;
    logic [15:0] leftOut, rightOut;
    logic        leftValid, rightValid, leftErr, rightErr;
    logic        pairValid, overrun;
    logic [1:0]  pair_state;

    always #5 clk_12 = ~clk_12;

    dac_serial_rx dut (
        .clk_12       (clk_12),
        .reset        (reset),
        .DL           (DL),
        .DR           (DR),
        .LL           (LL),
        .LR           (LR),
        .leftOut      (leftOut),
        .rightOut     (rightOut),
        .leftValid    (leftValid),
        .rightValid   (rightValid),
        .leftErr      (leftErr),
        .rightErr     (rightErr),
        .pairValid    (pairValid),
        .overrun      (overrun),
        .pair_state_o (pair_state)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lv_n, rv_n, pv_n, lv_cyc, rv_cyc, pv_cyc;
    sample_t last_left;

    logic [16:0] exp_l_q[$];
    logic [16:0] exp_r_q[$];
    logic [31:0] exp_p_q[$];
    logic [1:0]  lq[$];
    logic [1:0]  rq[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard
    always @(negedge clk_12) begin
        cyc++;
        if (!reset) begin
            if (leftValid) begin
                lv_n++;
                lv_cyc    = cyc;
                last_left = leftOut;
                check("lv_pending", 64'(exp_l_q.size() > 0), 64'd1);
                if (exp_l_q.size() > 0) check("lv_word", {leftErr, leftOut}, exp_l_q.pop_front());
            end
            if (rightValid) begin
                rv_n++;
                rv_cyc = cyc;
                check("rv_pending", 64'(exp_r_q.size() > 0), 64'd1);
                if (exp_r_q.size() > 0) check("rv_word", {rightErr, rightOut}, exp_r_q.pop_front());
            end
            if (pairValid) begin
                pv_n++;
                pv_cyc = cyc;
                check("pv_pending", 64'(exp_p_q.size() > 0), 64'd1);
                if (exp_p_q.size() > 0) check("pv_pair", {leftOut, rightOut}, exp_p_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic clear_counts();
        lv_n = 0; rv_n = 0; pv_n = 0;
        lv_cyc = 0; rv_cyc = 0; pv_cyc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_12);
        reset = 1'b1;
        DL = 1'b0; DR = 1'b0; LL = 1'b0; LR = 1'b0;
        @(negedge clk_12);
        @(negedge clk_12);
        check("rst_words", {leftOut, rightOut}, 64'd0);
        check("rst_flags", {leftValid, rightValid, leftErr, rightErr, pairValid, overrun}, 64'd0);
        check("rst_state", pair_state, 64'(IDLE));
        reset = 1'b0;
        clear_counts();
    endtask

    // Latch low on the MSB cycle, high for the rest: the fall marks the
    // boundary after the previous word's LSB.
    task automatic push_frame(input bit right, input logic [15:0] w, input int len);
        logic [1:0] v;
        for (int i = 0; i < len; i++) begin
            v = {w[len-1-i], (i != 0)};
            if (right) rq.push_back(v);
            else       lq.push_back(v);
        end
    endtask

    task automatic push_idle(input bit right, input int n);
        for (int i = 0; i < n; i++) begin
            if (right) rq.push_back(2'b00);
            else       lq.push_back(2'b00);
        end
    endtask

    task automatic play(input int flush);
        int n;
        logic [1:0] a, b;
        n = ((lq.size() > rq.size()) ? lq.size() : rq.size()) + flush;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_12);
            a = (lq.size() > 0) ? lq.pop_front() : 2'b00;
            b = (rq.size() > 0) ? rq.pop_front() : 2'b00;
            DL = a[1]; LL = a[0];
            DR = b[1]; LR = b[0];
        end
    endtask

    task automatic end_scenario(input string tag);
        check({tag, "_lq_left"}, exp_l_q.size(), 64'd0);
        check({tag, "_rq_left"}, exp_r_q.size(), 64'd0);
        check({tag, "_pq_left"}, exp_p_q.size(), 64'd0);
        exp_l_q.delete(); exp_r_q.delete(); exp_p_q.delete();
    endtask

    initial begin
        // simultaneous frames after an arming frame
        do_reset();
        push_frame(0, 16'h1234, 16); push_frame(0, 16'h0009, 16);
        push_frame(1, 16'h4321, 16); push_frame(1, 16'h0006, 16);
        exp_l_q.push_back({1'b0, 16'h0009});
        exp_r_q.push_back({1'b0, 16'h0006});
        exp_p_q.push_back({16'h0009, 16'h0006});
        play(8);
        check("s1_lv_count", lv_n, 64'd1);
        check("s1_same_cycle", rv_cyc, 64'(lv_cyc));
        check("s1_pv_lag", pv_cyc - lv_cyc, 64'd1);
        end_scenario("s1");

        // left leads right by 8 cycles
        do_reset();
        push_frame(0, 16'h0000, 16); push_frame(0, 16'h8000, 16);
        push_idle(1, 8);
        push_frame(1, 16'h0000, 16); push_frame(1, 16'h7FFF, 16);
        exp_l_q.push_back({1'b0, 16'h8000});
        exp_r_q.push_back({1'b0, 16'h7FFF});
        exp_p_q.push_back({16'h8000, 16'h7FFF});
        play(8);
        check("s2_rv_lag", rv_cyc - lv_cyc, 64'd8);
        check("s2_pv_lag", pv_cyc - rv_cyc, 64'd1);
        check("s2_signed", int'(last_left), -32768);
        end_scenario("s2");

        // 12-bit short frame, then a normal frame
        do_reset();
        push_frame(0, 16'h0000, 16); push_frame(0, 16'h0ABC, 12); push_frame(0, 16'h0123, 16);
        exp_l_q.push_back({1'b1, 16'h0ABC});
        exp_l_q.push_back({1'b0, 16'h0123});
        play(8);
        check("s3_pv_count", pv_n, 64'd0);
        end_scenario("s3");

        // two lefts before any right
        do_reset();
        push_frame(0, 16'h0000, 16); push_frame(0, 16'h0004, 16); push_frame(0, 16'h0005, 16);
        push_idle(1, 24);
        push_frame(1, 16'h0000, 16); push_frame(1, 16'h0008, 16);
        exp_l_q.push_back({1'b0, 16'h0004});
        exp_l_q.push_back({1'b0, 16'h0005});
        exp_r_q.push_back({1'b0, 16'h0008});
        exp_p_q.push_back({16'h0005, 16'h0008});
        play(8);
        check("s4_overrun", overrun, 64'd1);
        check("s4_state", pair_state, 64'(IDLE));
        end_scenario("s4");

        // latch held high for 300 cycles
        do_reset();
        push_frame(0, 16'h0000, 16);
        lq.push_back(2'b00);
        for (int i = 0; i < 300; i++) lq.push_back(2'b11);
        exp_l_q.push_back({1'b1, 16'hFFFF});
        play(8);
        check("s5_lv_count", lv_n, 64'd1);
        end_scenario("s5");

        // reset asserted mid-frame
        do_reset();
        push_frame(0, 16'h0000, 16); push_frame(0, 16'h1111, 16); push_frame(0, 16'h00FF, 8);
        push_frame(1, 16'h0000, 16); push_frame(1, 16'h2222, 16); push_frame(1, 16'h00FF, 8);
        exp_l_q.push_back({1'b0, 16'h1111});
        exp_r_q.push_back({1'b0, 16'h2222});
        exp_p_q.push_back({16'h1111, 16'h2222});
        play(0);
        check("s6_pre_words", {leftOut, rightOut}, {32'd0, 16'h1111, 16'h2222});
        #2;
        reset = 1'b1;
        DL = 1'b0; DR = 1'b0; LL = 1'b0; LR = 1'b0;
        #1;
        check("s6_rst_words", {leftOut, rightOut}, 64'd0);
        check("s6_rst_flags", {leftValid, rightValid, pairValid, overrun, pair_state}, 64'd0);
        @(negedge clk_12);
        reset = 1'b0;
        clear_counts();
        push_frame(0, 16'h0F0F, 16); push_frame(0, 16'h5A5A, 16);
        push_frame(1, 16'h3C3C, 16); push_frame(1, 16'hC3C3, 16);
        exp_l_q.push_back({1'b0, 16'h5A5A});
        exp_r_q.push_back({1'b0, 16'hC3C3});
        exp_p_q.push_back({16'h5A5A, 16'hC3C3});
        play(8);
        check("s6_lv_count", lv_n, 64'd1);
        end_scenario("s6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
